mips_mc_control: RTL and testbench

- Multicycle control FSM for the MIPS datapath; it drives the ALU's mode/operand-select interface and consumes its zero flag.
- Sequences fetch/decode/execute/memory/writeback across several clocks instead of one tact.
- Handshakes with a shared instruction/data memory port (request held until ready).
- Sits between the instruction register (opcode/funct in) and the datapath muxes, register file, PC and ALU.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/mips_alu_decode.sv | 41 ++++
 rtl/mips_mc_control.sv | 152 +++++++++++++++
 tb/tb_mips_mc_control.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control: ALU modes, opcode/funct
// constants, FSM states and datapath mux select values.
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_NAND = 4'b0101;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1001;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  // How the ALU mode is chosen in the current state.
  typedef enum logic [1:0] {
    ACLS_ADD, ACLS_SUB, ACLS_RTYPE, ACLS_ITYPE
  } alu_cls_t;

  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational ALU-mode decode from the control state class, opcode and funct.
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [1:0] i_cls,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_mode,
  output logic       o_funct_valid
);

  always_comb begin
    o_alu_mode    = ALU_ADD;
    o_funct_valid = 1'b1;
    case (i_cls)
      ACLS_SUB: o_alu_mode = ALU_SUB;
      ACLS_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_alu_mode = ALU_ADD;
          FN_SUB:  o_alu_mode = ALU_SUB;
          FN_AND:  o_alu_mode = ALU_AND;
          FN_OR:   o_alu_mode = ALU_OR;
          FN_XOR:  o_alu_mode = ALU_XOR;
          FN_NOR:  o_alu_mode = ALU_NOR;
          FN_SLT:  o_alu_mode = ALU_SLT;
          default: o_funct_valid = 1'b0;
        endcase
      end
      ACLS_ITYPE: begin
        case (i_opcode)
          OP_ANDI: o_alu_mode = ALU_AND;
          OP_ORI:  o_alu_mode = ALU_OR;
          OP_XORI: o_alu_mode = ALU_XOR;
          default: o_alu_mode = ALU_ADD;
        endcase
      end
      default: o_alu_mode = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: Moore decode of the state register, with
// memory-ready qualified fetch strobes and zero-qualified branch PC write.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter logic [3:0] RESET_MODE = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_mode,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  alu_cls_t   w_alu_cls;
  logic [3:0] w_alu_mode;
  logic       w_funct_valid;

  mips_alu_decode u_alu_decode (
    .i_cls         (w_alu_cls),
    .i_opcode      (opcode),
    .i_funct       (funct),
    .o_alu_mode    (w_alu_mode),
    .o_funct_valid (w_funct_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         w_next = S_EXEC_R;
          OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
          OP_J:                             w_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: w_next = S_EXEC_I;
          default:                          w_next = S_TRAP;
        endcase
      end
      S_EXEC_R:   w_next = w_funct_valid ? S_WB_R : S_TRAP;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (r_state)
      S_EXEC_R: w_alu_cls = ACLS_RTYPE;
      S_EXEC_I: w_alu_cls = ACLS_ITYPE;
      S_BRANCH: w_alu_cls = ACLS_SUB;
      default:  w_alu_cls = ACLS_ADD;
    endcase
  end

  // rst overrides the state decode so an aborted access drops its requests at once.
  always_comb begin
    alu_mode   = w_alu_mode;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    imm_zext   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      alu_mode = RESET_MODE;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = SRCB_IMM_SH;
        S_EXEC_R:   alu_src_a = 1'b1;
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          imm_zext  = is_zext_op(opcode);
        end
        S_WB_I:     reg_write = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_src    = PCSRC_ALUOUT;
          pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        end
        S_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control: an instruction-step queue model checks
// every output each cycle; directed sequences pin the model with literal values.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [3:0] alu_mode;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext, pc_write;
  logic [1:0] pc_src;
  logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  mips_mc_control #(.RESET_MODE(4'b1000)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_mode(alu_mode), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_write(pc_write),
    .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {K_FETCH, K_DECODE, K_EXR, K_WBR, K_EXI, K_WBI, K_ADDR,
                    K_MRD, K_WBM, K_MWR, K_BR, K_J, K_TRAP} step_t;

  typedef struct packed {
    logic [3:0] mode; logic [1:0] srcb; logic [1:0] pcsrc;
    logic srca, iord, regdst, m2r, zext, mr, mw, irw, pcw, regw, ill;
  } ov_t;

  step_t cur = K_FETCH;
  step_t pend[$];

  // {valid, mode} for an R-type funct
  function automatic logic [4:0] r_mode(input logic [5:0] fn);
    case (fn)
      6'b100000: return 5'b1_1000;
      6'b100010: return 5'b1_1001;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b100110: return 5'b1_0010;
      6'b100111: return 5'b1_0011;
      6'b101010: return 5'b1_0100;
      default:   return 5'b0_0000;
    endcase
  endfunction

  function automatic int base_lat(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b101011: return 4;
      6'b100011: return 5;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default: return 0;
    endcase
  endfunction

  // Remaining steps of an instruction after DECODE.
  task automatic plan(input logic [5:0] op);
    pend.delete();
    case (op)
      6'b000000: begin pend.push_back(K_EXR); pend.push_back(K_WBR); end
      6'b100011: begin pend.push_back(K_ADDR); pend.push_back(K_MRD); pend.push_back(K_WBM); end
      6'b101011: begin pend.push_back(K_ADDR); pend.push_back(K_MWR); end
      6'b000100, 6'b000101: pend.push_back(K_BR);
      6'b000010: pend.push_back(K_J);
      6'b001000, 6'b001100, 6'b001101, 6'b001110: begin pend.push_back(K_EXI); pend.push_back(K_WBI); end
      default: pend.push_back(K_TRAP);
    endcase
  endtask

  // Compare process: check all outputs, then advance the model.
  logic prev_fetch = 1'b0;
  bit   inflight = 0;
  int   lat_cnt = 0, waits = 0, exp_lat = 0;

  always @(negedge clk) begin
    ov_t e, m, a;
    logic [4:0] rm;
    logic fetchlike;
    e = '0; m = '0;
    m.mr = 1; m.mw = 1; m.irw = 1; m.pcw = 1; m.regw = 1; m.ill = 1;
    a = {alu_mode, alu_src_b, pc_src, alu_src_a, iord, reg_dst, mem_to_reg, imm_zext,
         mem_read, mem_write, ir_write, pc_write, reg_write, illegal};
    if (rst) begin
      m = '1; e.mode = 4'b1000;
    end else begin
      case (cur)
        K_FETCH: begin
          e.mr = 1; e.srcb = 2'b01; e.mode = 4'b1000; e.irw = mem_ready; e.pcw = mem_ready;
          m.iord = 1; m.srca = 1; m.srcb = '1; m.mode = '1; m.pcsrc = '1;
        end
        K_DECODE: begin e.srcb = 2'b11; e.mode = 4'b1000; m.srca = 1; m.srcb = '1; m.mode = '1; end
        K_EXR: begin
          rm = r_mode(funct);
          e.srca = 1; m.srca = 1; m.srcb = '1;
          if (rm[4]) begin e.mode = rm[3:0]; m.mode = '1; end
        end
        K_WBR: begin e.regw = 1; e.regdst = 1; m.regdst = 1; m.m2r = 1; end
        K_EXI: begin
          e.srca = 1; e.srcb = 2'b10; m.srca = 1; m.srcb = '1; m.mode = '1; m.zext = 1;
          case (opcode)
            6'b001100: begin e.mode = 4'b0000; e.zext = 1; end
            6'b001101: begin e.mode = 4'b0001; e.zext = 1; end
            6'b001110: begin e.mode = 4'b0010; e.zext = 1; end
            default:   e.mode = 4'b1000;
          endcase
        end
        K_WBI: begin e.regw = 1; m.regdst = 1; end
        K_ADDR: begin e.srca = 1; e.srcb = 2'b10; e.mode = 4'b1000; m.srca = 1; m.srcb = '1; m.mode = '1; end
        K_MRD: begin e.mr = 1; e.iord = 1; m.iord = 1; end
        K_WBM: begin e.regw = 1; e.m2r = 1; m.m2r = 1; m.regdst = 1; end
        K_MWR: begin e.mw = 1; e.iord = 1; m.iord = 1; end
        K_BR: begin
          e.srca = 1; e.mode = 4'b1001; e.pcsrc = 2'b01;
          e.pcw = (opcode == 6'b000101) ? ~zero : zero;
          m.srca = 1; m.srcb = '1; m.mode = '1; m.pcsrc = '1;
        end
        K_J: begin e.pcsrc = 2'b10; e.pcw = 1; m.pcsrc = '1; end
        K_TRAP: e.ill = 1;
        default: ;
      endcase
    end
    n_checks++;
    if (((a ^ e) & m) !== '0) begin
      n_fail++;
      $display("FAIL step_%s t=%0t got=%h want=%h mask=%h", rst ? "RESET" : cur.name(), $time, a, e, m);
    end

    // Instruction latency measured from the DUT's fetch boundaries.
    fetchlike = mem_read & ~iord;
    if (rst) begin
      inflight = 0;
    end else begin
      if (fetchlike && !prev_fetch) begin
        if (inflight) begin
          n_checks++;
          if (lat_cnt != exp_lat + waits) begin
            n_fail++;
            $display("FAIL latency t=%0t got=%0d want=%0d", $time, lat_cnt, exp_lat + waits);
          end
        end
        inflight = 1; lat_cnt = 0; waits = 0; exp_lat = 0;
      end
      if (inflight) begin
        lat_cnt++;
        if ((fetchlike || (iord && (mem_read || mem_write))) && !mem_ready) waits++;
        if (cur == K_DECODE) exp_lat = base_lat(opcode);
        if (illegal) inflight = 0;
      end
    end
    prev_fetch = rst ? 1'b0 : fetchlike;

    // Advance the model to the step of the next cycle.
    if (rst) begin
      cur = K_FETCH; pend.delete();
    end else begin
      case (cur)
        K_FETCH: if (mem_ready) cur = K_DECODE;
        K_DECODE: begin plan(opcode); cur = pend.pop_front(); end
        K_TRAP: cur = K_TRAP;
        K_MRD, K_MWR: if (mem_ready) cur = (pend.size() != 0) ? pend.pop_front() : K_FETCH;
        K_EXR: begin
          rm = r_mode(funct);
          if (!rm[4]) begin cur = K_TRAP; pend.delete(); end
          else cur = (pend.size() != 0) ? pend.pop_front() : K_FETCH;
        end
        default: cur = (pend.size() != 0) ? pend.pop_front() : K_FETCH;
      endcase
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, want);
    end
  endtask

  task automatic tick(input logic mr);
    @(posedge clk); #1;
    mem_ready = mr;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; returns at the next FETCH or TRAP.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, input bit allow_rst);
    int fl, ml;
    bit left;
    fl = fw; ml = mw; left = 0;
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < 64; i++) begin
      if (cur != K_FETCH) left = 1;
      if ((left && cur == K_FETCH) || cur == K_TRAP) return;
      if (cur == K_FETCH) begin mem_ready = (fl == 0); if (fl > 0) fl--; end
      else if (cur == K_MRD || cur == K_MWR) begin mem_ready = (ml == 0); if (ml > 0) ml--; end
      else mem_ready = 1'($urandom);
      if (allow_rst && $urandom_range(0, 79) == 0) begin
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL run_timeout t=%0t", $time);
  endtask

  logic [5:0] ops [0:10];
  logic [5:0] fns [0:6];

  initial begin
    logic [5:0] op, fn;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lit("reset_mode", {4'b0, alu_mode}, 8'b0000_1000);
    lit("reset_strobes", {mem_read, mem_write, ir_write, pc_write, reg_write, illegal, iord, alu_src_a}, 8'h00);
    rst = 1'b0; #1;

    // R-type add, zero-wait memory
    opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1; #1;
    lit("radd_fetch", {4'b0, mem_read, iord, ir_write, pc_write}, 8'b0000_1011);
    tick(1); lit("radd_decode_srcb", {6'b0, alu_src_b}, 8'b0000_0011);
    tick(1); lit("radd_exec_mode", {3'b0, alu_src_a, alu_mode}, 8'b0001_1000);
    tick(1); lit("radd_wb", {5'b0, reg_write, reg_dst, mem_to_reg}, 8'b0000_0110);
    tick(1); lit("radd_next_fetch", {6'b0, mem_read, iord}, 8'b0000_0010);
    // slt
    funct = 6'b101010;
    tick(1); tick(1); lit("slt_exec_mode", {4'b0, alu_mode}, 8'b0000_0100);
    tick(1); tick(1);
    // beq taken
    opcode = 6'b000100; zero = 1'b1;
    tick(1); tick(1); lit("beq_branch", {1'b0, pc_write, pc_src, alu_mode}, 8'b0101_1001);
    tick(1); lit("beq_back_fetch", {7'b0, mem_read}, 8'd1);
    // bne with zero=1: no PC write
    opcode = 6'b000101;
    tick(1); tick(1); lit("bne_branch", {5'b0, pc_write, pc_src}, 8'b0000_0001);
    tick(1); lit("bne_back_fetch", {7'b0, mem_read}, 8'd1);
    // andi
    opcode = 6'b001100; funct = 6'($urandom);
    tick(1); tick(1); lit("andi_exec", {1'b0, imm_zext, alu_src_b, alu_mode}, 8'b0110_0000);
    tick(1); lit("andi_wb", {6'b0, reg_write, reg_dst}, 8'b0000_0010);
    tick(1);
    // lw with three wait cycles in MEM_RD
    opcode = 6'b100011;
    tick(1); tick(1);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3);
      lit("lw_memrd_hold", {6'b0, mem_read, iord}, 8'b0000_0011);
    end
    tick(1); lit("lw_wbmem", {6'b0, reg_write, mem_to_reg}, 8'b0000_0011);
    tick(1); lit("lw_back_fetch", {6'b0, mem_read, iord}, 8'b0000_0010);
    // reset in the middle of a stalled MEM_RD
    tick(1); tick(1); tick(0);
    rst = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      lit("rst_mid_access", {mem_read, mem_write, reg_write, pc_write, ir_write, iord, 2'b0}, 8'h00);
      lit("rst_mid_mode", {4'b0, alu_mode}, 8'b0000_1000);
      tick(0);
    end
    rst = 1'b0; mem_ready = 1'b1; #1;
    lit("post_rst_fetch", {6'b0, mem_read, iord}, 8'b0000_0010);
    // illegal opcode, then illegal funct
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 6'b111111 : 6'b000000;
      funct  = 6'b000001;
      tick(1); tick(1);
      if (k == 1) tick(1);
      for (int i = 0; i < 20; i++) begin
        lit("illegal_sticky", {mem_read, mem_write, reg_write, pc_write, ir_write, illegal, 2'b0}, 8'b0000_0100);
        tick(1'($urandom));
      end
      do_reset(2); mem_ready = 1'b1; #1;
      lit("illegal_cleared", {7'b0, illegal}, 8'd0);
    end

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 15))
        0: op = 6'($urandom);
        default: op = ops[$urandom_range(0, 10)];
      endcase
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      run_instr(op, fn, 1'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, 1'b1);
      if (cur == K_TRAP) begin
        repeat ($urandom_range(1, 4)) begin mem_ready = 1'($urandom); @(posedge clk); #1; end
        do_reset(1);
      end
    end
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
